// File: rtl/input_acc_multi.sv
// input_acc_multi: LANES independent input FIFOs feeding systolic-array rows.
// One read command drains all lanes; lane i output is delayed i extra cycles.
// Supports host/NN-writeback writes, sticky overflow/underflow, flush, and a
// non-destructive replay mode with rewind.
module input_acc_multi #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LANES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      input_acc_valid_in,
  input  logic [LANES-1:0]          input_acc_valid_data_in,
  input  logic [LANES*DATA_W-1:0]   input_acc_data_in,
  input  logic [LANES-1:0]          input_acc_valid_data_nn_in,
  input  logic [LANES*DATA_W-1:0]   input_acc_data_nn_in,
  input  logic                      input_acc_replay_in,
  input  logic                      input_acc_rewind_in,
  input  logic                      input_acc_clear_in,
  output logic [LANES-1:0]          input_acc_valid_out,
  output logic [LANES*DATA_W-1:0]   input_acc_data_out,
  output logic [LANES-1:0]          input_acc_full_out,
  output logic [LANES-1:0]          input_acc_empty_out,
  output logic [LANES-1:0]          input_acc_overflow_out,
  output logic [LANES-1:0]          input_acc_underflow_out
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = CNT_W + 1;

  // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic r_replay_d;
  logic w_replay_fall;

  // Previous replay level, used to detect leaving replay mode.
  always_ff @(posedge clk) begin
    if (rst) r_replay_d <= 1'b0;
    else     r_replay_d <= input_acc_replay_in;
  end

  assign w_replay_fall = r_replay_d & ~input_acc_replay_in;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_off;
    logic              r_full;
    logic              r_empty;
    logic              r_ovf;
    logic              r_udf;
    logic [DATA_W-1:0] r_sk_d [0:gi];
    logic              r_sk_v [0:gi];

    logic              w_wr_req;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_readable;
    logic              w_rd_en;
    logic              w_pop;
    logic              w_wr_acc;
    logic              w_drop;
    logic              w_udf_ev;
    logic [IDX_W-1:0]  w_sum;
    logic [PTR_W-1:0]  w_rd_idx;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  w_off_nxt;

    // Per-lane read/write decisions; clear suppresses every access.
    always_comb begin
      w_wr_req    = 1'b0;
      w_wr_data   = '0;
      w_readable  = 1'b0;
      w_rd_en     = 1'b0;
      w_pop       = 1'b0;
      w_wr_acc    = 1'b0;
      w_drop      = 1'b0;
      w_udf_ev    = 1'b0;
      w_sum       = '0;
      w_rd_idx    = r_head;
      w_count_nxt = r_count;
      w_off_nxt   = r_off;

      w_wr_req  = input_acc_valid_data_nn_in[gi] | input_acc_valid_data_in[gi];
      w_wr_data = input_acc_valid_data_nn_in[gi] ?
                  input_acc_data_nn_in[gi*DATA_W +: DATA_W] :
                  input_acc_data_in[gi*DATA_W +: DATA_W];

      w_readable = input_acc_replay_in ? (r_off < r_count) : (r_count != '0);

      w_sum = IDX_W'(r_head) + IDX_W'(r_off);
      if (w_sum >= IDX_W'(DEPTH)) w_sum = w_sum - IDX_W'(DEPTH);
      if (input_acc_replay_in) w_rd_idx = PTR_W'(w_sum);

      if (!input_acc_clear_in) begin
        w_rd_en  = input_acc_valid_in & w_readable;
        w_udf_ev = input_acc_valid_in & ~w_readable;
        w_pop    = w_rd_en & ~input_acc_replay_in;
        w_wr_acc = w_wr_req & ((r_count < CNT_W'(DEPTH)) | w_pop);
        w_drop   = w_wr_req & ~w_wr_acc;
      end

      w_count_nxt = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_pop);

      // Rewind wins over a same-cycle replay read, which used the old offset.
      if (input_acc_rewind_in || w_replay_fall) w_off_nxt = '0;
      else if (w_rd_en && input_acc_replay_in)  w_off_nxt = r_off + CNT_W'(1);
    end

    // Lane pointers, occupancy, flags.
    always_ff @(posedge clk) begin
      if (rst || input_acc_clear_in) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_off   <= '0;
        r_full  <= 1'b0;
        r_empty <= 1'b1;
        r_ovf   <= 1'b0;
        r_udf   <= 1'b0;
      end else begin
        if (w_pop)    r_head <= f_inc(r_head);
        if (w_wr_acc) r_tail <= f_inc(r_tail);
        r_count <= w_count_nxt;
        r_off   <= w_off_nxt;
        r_full  <= (w_count_nxt == CNT_W'(DEPTH));
        r_empty <= (w_count_nxt == '0);
        r_ovf   <= r_ovf | w_drop;
        r_udf   <= r_udf | w_udf_ev;
      end
    end

    // Storage; contents are never observable before being written.
    always_ff @(posedge clk) begin
      if (w_wr_acc && !rst) r_mem[r_tail] <= w_wr_data;
    end

    // Read register plus gi skew stages; data holds while valid is low.
    always_ff @(posedge clk) begin
      if (rst || input_acc_clear_in) begin
        for (int k = 0; k <= gi; k++) begin
          r_sk_v[k] <= 1'b0;
          r_sk_d[k] <= '0;
        end
      end else begin
        r_sk_v[0] <= w_rd_en;
        if (w_rd_en) r_sk_d[0] <= r_mem[w_rd_idx];
        for (int k = 1; k <= gi; k++) begin
          r_sk_v[k] <= r_sk_v[k-1];
          if (r_sk_v[k-1]) r_sk_d[k] <= r_sk_d[k-1];
        end
      end
    end

    assign input_acc_valid_out[gi]                  = r_sk_v[gi];
    assign input_acc_data_out[gi*DATA_W +: DATA_W]  = r_sk_d[gi];
    assign input_acc_full_out[gi]                   = r_full;
    assign input_acc_empty_out[gi]                  = r_empty;
    assign input_acc_overflow_out[gi]               = r_ovf;
    assign input_acc_underflow_out[gi]              = r_udf;
  end

endmodule

// File: doc/input_acc_multi.md
# input_acc_multi

Parametrised multi-lane successor to the single-lane input accumulator FIFO. It holds `LANES` independent FIFOs, one per systolic-array row, each filled from a host or NN-writeback source. All lanes are drained by a single read command. Lane outputs are skewed by lane index so that row `i` enters the array `i` cycles after row 0. It adds full/empty flags, sticky overflow/underflow, write-through-on-full, flush, and a replay mode that re-streams stored vectors without consuming them.

## Interface
- `DATA_W`, 16, signed sample width
- `DEPTH`, 4, entries per lane; any value ≥ 2, not required to be a power of two
- `LANES`, 2, number of lanes/rows; ≥ 1
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset; one clock, synchronous and active-high
- `input_acc_valid_in`  in  1  read command, applies to all lanes
- `input_acc_valid_data_in`  in  LANES  per-lane host write valid
- `input_acc_data_in`  in  LANES*DATA_W  host data, lane i at bits [i*DATA_W +: DATA_W]
- `input_acc_valid_data_nn_in`  in  LANES  per-lane NN-writeback valid
- `input_acc_data_nn_in`  in  LANES*DATA_W  NN-writeback data, same packing
- `input_acc_replay_in`  in  1  level; 1 = replay mode (reads do not pop)
- `input_acc_rewind_in`  in  1  pulse; reset all replay cursors to head
- `input_acc_clear_in`  in  1  pulse; flush all lanes and sticky flags
- `input_acc_valid_out`  out  LANES  per-lane output valid (skewed)
- `input_acc_data_out`  out  LANES*DATA_W  per-lane output data (skewed)
- `input_acc_full_out`  out  LANES  lane count == DEPTH
- `input_acc_empty_out`  out  LANES  lane count == 0
- `input_acc_overflow_out`  out  LANES  sticky: write dropped
- `input_acc_underflow_out`  out  LANES  sticky: read command found nothing readable

## Operation
- Per lane, the write source is `nn` if `valid_data_nn_in[i]`, otherwise host. `wr_en[i] = nn_valid | host_valid`. NN wins when both are set.
- Per-lane state: `head`, `tail` (0..DEPTH-1, wrap DEPTH-1→0), `count` (0..DEPTH), and replay offset `off` (0..DEPTH).
- Readable: normal mode `count != 0`; replay mode `off < count`.
- Read word: `mem[head]` in normal mode; `mem[(head+off) mod DEPTH]` in replay mode.
- `rd_en[i] = valid_in & readable[i]`.
- Normal-mode read pops: head advances, count decrements.
- Replay-mode read increments `off` only. Head and count do not change.
- Write accepted when `count < DEPTH`, or when the lane pops in the same cycle (normal mode only). The write stores at `tail` and advances tail.
- Count update: accepted write only → +1; pop only → −1; both → unchanged.
- Write rejected (full and no same-cycle pop): data dropped, `overflow[i]` set.
- `valid_in` with the lane not readable: `underflow[i]` set. Nothing is emitted for that lane; other lanes are unaffected.
- `rewind_in`: `off ← 0` in all lanes. A read in the same cycle uses the pre-rewind offset.
- Replay falling edge (1→0): `off ← 0`. Stored entries are retained and the next normal read returns head.
- `clear_in`: head, tail, count, and off go to 0; sticky flags clear; the skew pipeline is flushed. Any write or read in that cycle is ignored. `clear_in` has priority over everything except `rst`.
- Skew: lane i output passes through `i` extra register stages after the read register.

## Timing
- Read latency: command at edge t → lane 0 valid/data at t+1, lane i at t+1+i. Back-to-back commands give back-to-back outputs per lane.
- `valid_out[i]` is high exactly one cycle per successful read. Data holds its last value when valid is low.
- Write to an empty lane at edge t is readable by a command at edge t+1, not at t.
- full/empty/count are registered and reflect the state after the edge.
- Reset (also mid-operation): all pointers, counts, offsets, and skew stages go to 0. `valid_out`, `data_out`, full, overflow, and underflow are 0; `empty_out` is all-ones. Memory contents are undefined and never observable.

## Test plan
- DEPTH=4, LANES=2: write 10,20,30,40 to lane 0 and 1,2,3,4 to lane 1, then 4 reads → lane 0 outputs 10,20,30,40 on cycles t+1..t+4, lane 1 outputs 1,2,3,4 on t+2..t+5; both lanes empty afterwards.
- Fill lane 0 with 4 words; write 50 with no read → dropped, overflow[0]=1, count stays 4. Then write 60 together with a read → read returns head; 60 is accepted, count stays 4, and 60 appears as the 4th subsequent read.
- Host 7 and NN −3 written to lane 1 in the same cycle → only −3 stored; a later read returns −3.
- Lane 0 holds 5,6, lane 1 empty, then one read → lane 0 valid with 5, lane 1 never valid, underflow = 2'b10.
- Replay=1 with lane 0 holding 1,2,3: 3 reads → 1,2,3, count stays 3; 4th read → underflow[0]. Rewind, then 2 reads → 1,2. Replay=0, then a read → 1 and count becomes 2.
- Mid-stream `clear_in`, then `rst` during skewed output → all outputs drop to 0 the next cycle, empty all-ones, no stale valid emerges from the skew stages.
